axi_stream_input: RTL

AXI4-Stream slave that receives a character frame, one `CHAR_LEN-bit beat per character. It buffers the beats in a 32-entry FIFO and packs them into a flat N*CHAR_LEN vector for the compute core. It is the receive-side counterpart of the stream output block: it accepts frames terminated by TLAST on beat N-1 and presents them to the core, which works under the same run/valid convention.

---
 rtl/axi_stream_input.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/axi_stream_input.sv
// rtl/axi_stream_input.sv - AXI4-Stream character frame receiver with input FIFO (optional frame-length check: AXIS_IN_FRAME_CHECK_EN)

`ifndef N
`define N 4
`endif
`ifndef CHAR_LEN
`define CHAR_LEN 8
`endif

module axi_stream_input #(
    parameter int N         = `N,
    parameter int CHAR_LEN  = `CHAR_LEN,
    parameter int FIFO_SIZE = 32,
    parameter int LOG_SIZE  = 5
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [CHAR_LEN-1:0]   S_AXIS_TDATA,
    input  logic                  S_AXIS_TLAST,
    input  logic                  S_AXIS_TVALID,
    output logic                  S_AXIS_TREADY,
    input  logic                  run,
    output logic [N*CHAR_LEN-1:0] q,
    output logic                  valid
`ifdef AXIS_IN_FRAME_CHECK_EN
    ,
    output logic                  err
`endif
);

    localparam int              W        = CHAR_LEN + 1;
    localparam logic [3:0]      LAST_IDX = 4'(N - 1);
    localparam logic [LOG_SIZE:0] PTR_ONE = 1;

`ifdef AXIS_IN_FRAME_CHECK_EN
    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE, S_DROP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE} state_t;
`endif

    // FIFO storage: each entry is {TLAST, TDATA}; pointers carry an extra wrap bit
    logic [W-1:0]      mem_q [FIFO_SIZE];
    logic [LOG_SIZE:0] wr_ptr_q;
    logic [LOG_SIZE:0] rd_ptr_q;
    logic              fifo_full;
    logic              fifo_empty;
    logic              we;
    logic              re;
    logic [W-1:0]      data_r;
    logic [CHAR_LEN-1:0] rd_char;

    state_t              state_q, state_d;
    logic [3:0]          count_q, count_d;
    logic [N*CHAR_LEN-1:0] q_q, q_d;

    assign fifo_empty    = (wr_ptr_q == rd_ptr_q);
    assign fifo_full     = (wr_ptr_q[LOG_SIZE] != rd_ptr_q[LOG_SIZE]) &&
                           (wr_ptr_q[LOG_SIZE-1:0] == rd_ptr_q[LOG_SIZE-1:0]);
    assign S_AXIS_TREADY = ~fifo_full;
    assign we            = S_AXIS_TVALID & ~fifo_full;
    assign data_r        = mem_q[rd_ptr_q[LOG_SIZE-1:0]];
    assign rd_char       = data_r[CHAR_LEN-1:0];

`ifdef AXIS_IN_FRAME_CHECK_EN
    logic err_q, err_d;
    logic rd_last;
    assign rd_last = data_r[CHAR_LEN];
    assign re      = ~fifo_empty & ((state_q == S_RECV) | (state_q == S_DROP));
    assign err     = err_q;
`else
    // Frame end marker is kept in the FIFO but the frame is a fixed beat count
    logic unused_last;
    assign unused_last = data_r[CHAR_LEN];
    assign re          = ~fifo_empty & (state_q == S_RECV);
`endif

    assign q     = q_q;
    assign valid = (state_q == S_DONE);

    // FIFO entry write; storage needs no reset because the pointers gate visibility
    always_ff @(posedge ACLK) begin
        if (we) begin
            mem_q[wr_ptr_q[LOG_SIZE-1:0]] <= {S_AXIS_TLAST, S_AXIS_TDATA};
        end
    end

    // FIFO pointer advance on accepted beats and on consumer reads
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (we) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (re) rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Frame assembly: next state, slot writes and beat counting
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        q_d     = q_q;
`ifdef AXIS_IN_FRAME_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                count_d = '0;
                if (run) begin
                    state_d = S_RECV;
`ifdef AXIS_IN_FRAME_CHECK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_RECV: begin
                if (!run) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (re) begin
                    for (int i = 0; i < N; i++) begin
                        if (4'(i) == count_q) begin
                            q_d[i*CHAR_LEN +: CHAR_LEN] = rd_char;
                        end
`ifdef AXIS_IN_FRAME_CHECK_EN
                        // A short frame clears the slots it never reached
                        else if (rd_last && (4'(i) > count_q)) begin
                            q_d[i*CHAR_LEN +: CHAR_LEN] = '0;
                        end
`endif
                    end
                    if (count_q == LAST_IDX) begin
                        count_d = '0;
`ifdef AXIS_IN_FRAME_CHECK_EN
                        state_d = rd_last ? S_DONE : S_DROP;
                        if (!rd_last) err_d = 1'b1;
`else
                        state_d = S_DONE;
`endif
                    end
`ifdef AXIS_IN_FRAME_CHECK_EN
                    else if (rd_last) begin
                        count_d = '0;
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
`endif
                    else begin
                        count_d = count_q + 4'd1;
                    end
                end
            end
`ifdef AXIS_IN_FRAME_CHECK_EN
            S_DROP: begin
                if (!run) begin
                    state_d = S_IDLE;
                end else if (re && rd_last) begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (!run) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Frame state registers
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= S_IDLE;
            count_q <= '0;
            q_q     <= '0;
`ifdef AXIS_IN_FRAME_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            q_q     <= q_d;
`ifdef AXIS_IN_FRAME_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

endmodule
